// File: rtl/ising_pkg.sv
// ising_pkg: address map shared by the loader and ising_axi,
// plus the loader FSM state encoding and address helpers.
package ising_pkg;

  localparam logic [31:0] START_ADDR       = 32'h0000_0000;
  localparam logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0004;
  localparam logic [31:0] CTR_MAX_ADDR     = 32'h0000_0008;
  localparam logic [31:0] PHASE_ADDR_BASE  = 32'h0000_1000;
  localparam logic [31:0] WEIGHT_ADDR_BASE = 32'h0010_0000;

  localparam int ROW_SHIFT = 2;
  localparam int COL_SHIFT = 13;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_CUT,
    S_CFG_MAX,
    S_EDGE,
    S_EDGE_B,
    S_START,
    S_RUN,
    S_READ,
    S_RESULT
  } ld_state_t;

  function automatic logic [31:0] weight_addr(
    input logic [31:0] r,
    input logic [31:0] c
  );
    return WEIGHT_ADDR_BASE
         + (r << ROW_SHIFT)
         + (c << COL_SHIFT);
  endfunction

  function automatic logic [31:0] phase_addr(
    input logic [31:0] slot
  );
    return PHASE_ADDR_BASE + (slot << ROW_SHIFT);
  endfunction

endpackage

// File: rtl/ising_phase_reader.sv
// ising_phase_reader: streams N phase reads (one address per cycle),
// thresholds each returned word against cutoff and packs the spins.
// Ports: start pulse in; araddr/rdata to ising_axi; done pulse and
// spins (bit k = spin k, valid from done onwards) out.
module ising_phase_reader
  import ising_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  cutoff,
  input  logic [31:0]  rdata,
  output logic [31:0]  araddr,
  output logic         done,
  output logic [N-1:0] spins
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] KLAST = IW'(N - 1);

  // pres: araddr carries spin pk this cycle.
  // cap: rdata carries spin ck this cycle.
  logic          pres_q;
  logic          cap_q;
  logic [IW-1:0] pk_q;
  logic [IW-1:0] ck_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pres_q <= 1'b0;
      cap_q  <= 1'b0;
      pk_q   <= '0;
      ck_q   <= '0;
      araddr <= '0;
      done   <= 1'b0;
      spins  <= '0;
    end else begin
      cap_q <= pres_q;
      ck_q  <= pk_q;
      done  <= cap_q && (ck_q == KLAST);
      if (cap_q) begin
        spins[ck_q] <= (rdata >= cutoff);
      end
      // spin k lives in phase slot N-1-k
      if (start) begin
        pres_q <= 1'b1;
        pk_q   <= '0;
        araddr <= phase_addr(32'(N - 1));
      end else if (pres_q) begin
        if (pk_q == KLAST) begin
          pres_q <= 1'b0;
        end else begin
          pk_q   <= pk_q + 1'b1;
          araddr <= phase_addr(32'(N - 2) - 32'(pk_q));
        end
      end
    end
  end

endmodule

// File: rtl/ising_loader.sv
// ising_loader: command sequencer in front of ising_axi. Programs
// cutoff/max, writes couplings symmetrically, starts the machine,
// waits run_cycles, reads phases and returns thresholded spins.
// Ports: cmd_* config in; edge_* valid/ready stream in;
// wready/wr_addr/wdata and araddr/rdata to ising_axi;
// res_valid/res_ready/res_spins out; busy, sticky err.
module ising_loader
  import ising_pkg::*;
#(
  parameter  int N           = 8,
  parameter  int NUM_WEIGHTS = 5,
  parameter  int RUN_W       = 32,
  localparam int IW          = $clog2(N),
  localparam int WW          = $clog2(NUM_WEIGHTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic [31:0]      ctr_cutoff,
  input  logic [31:0]      ctr_max,
  input  logic [31:0]      start_val,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic             edge_valid,
  output logic             edge_ready,
  input  logic [IW-1:0]    edge_i,
  input  logic [IW-1:0]    edge_j,
  input  logic [WW-1:0]    edge_w,
  input  logic             edge_last,
  output logic             wready,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wdata,
  output logic [31:0]      araddr,
  input  logic [31:0]      rdata,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_spins,
  output logic             busy,
  output logic             err
);

  ld_state_t state, state_d;

  logic [31:0]      cut_q, cut_d;
  logic [31:0]      max_q, max_d;
  logic [31:0]      sv_q, sv_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_q, pend_d;
  logic             last_q, last_d;

  logic             wready_d;
  logic [31:0]      wr_addr_d;
  logic [31:0]      wdata_d;
  logic             edge_ready_d;
  logic             res_valid_d;
  logic [N-1:0]     res_spins_d;
  logic             busy_d;
  logic             err_d;

  logic             rd_start;
  logic             rd_done;
  logic [N-1:0]     rd_spins;

  logic [31:0]      ri;
  logic [31:0]      ci;
  logic             bad;
  logic             diag;
  logic [31:0]      wcode;

  assign ri    = 32'(edge_i);
  assign ci    = 32'(edge_j);
  assign bad   = (ri >= 32'(N)) || (ci >= 32'(N));
  assign diag  = !bad && (edge_i == edge_j);
  assign wcode = 32'(edge_w);

  always_comb begin
    state_d      = state;
    cut_d        = cut_q;
    max_d        = max_q;
    sv_d         = sv_q;
    run_d        = run_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    last_d       = last_q;
    wready_d     = 1'b0;
    wr_addr_d    = wr_addr;
    wdata_d      = wdata;
    edge_ready_d = 1'b0;
    res_valid_d  = res_valid;
    res_spins_d  = res_spins;
    busy_d       = busy;
    err_d        = err;
    rd_start     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (cmd_start) begin
          cut_d     = ctr_cutoff;
          max_d     = ctr_max;
          sv_d      = start_val;
          run_d     = run_cycles;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          wready_d  = 1'b1;
          wr_addr_d = CTR_CUTOFF_ADDR;
          wdata_d   = ctr_cutoff;
          state_d   = S_CFG_CUT;
        end
      end
      S_CFG_CUT: begin
        wready_d  = 1'b1;
        wr_addr_d = CTR_MAX_ADDR;
        wdata_d   = max_q;
        state_d   = S_CFG_MAX;
      end
      S_CFG_MAX: begin
        edge_ready_d = 1'b1;
        state_d      = S_EDGE;
      end
      S_EDGE: begin
        edge_ready_d = 1'b1;
        if (edge_valid) begin
          unique case (1'b1)
            bad: begin
              err_d = 1'b1;
            end
            diag: begin
              wready_d  = 1'b1;
              wr_addr_d = weight_addr(ri, ri);
              wdata_d   = wcode;
            end
            default: begin
              wready_d     = 1'b1;
              wr_addr_d    = weight_addr(ri, ci);
              wdata_d      = wcode;
              pend_d       = weight_addr(ci, ri);
              last_d       = edge_last;
              edge_ready_d = 1'b0;
              state_d      = S_EDGE_B;
            end
          endcase
          if (edge_last && (bad || diag)) begin
            edge_ready_d = 1'b0;
            state_d      = S_START;
          end
        end
      end
      S_EDGE_B: begin
        wready_d  = 1'b1;
        wr_addr_d = pend_q;
        wdata_d   = wdata;
        if (last_q) begin
          state_d = S_START;
        end else begin
          edge_ready_d = 1'b1;
          state_d      = S_EDGE;
        end
      end
      S_START: begin
        wready_d  = 1'b1;
        wr_addr_d = START_ADDR;
        wdata_d   = sv_q;
        cnt_d     = run_q;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          rd_start = 1'b1;
          state_d  = S_READ;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_READ: begin
        if (rd_done) begin
          res_valid_d = 1'b1;
          res_spins_d = rd_spins;
          state_d     = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cut_q      <= '0;
      max_q      <= '0;
      sv_q       <= '0;
      run_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      last_q     <= 1'b0;
      wready     <= 1'b0;
      wr_addr    <= '0;
      wdata      <= '0;
      edge_ready <= 1'b0;
      res_valid  <= 1'b0;
      res_spins  <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      cut_q      <= cut_d;
      max_q      <= max_d;
      sv_q       <= sv_d;
      run_q      <= run_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      last_q     <= last_d;
      wready     <= wready_d;
      wr_addr    <= wr_addr_d;
      wdata      <= wdata_d;
      edge_ready <= edge_ready_d;
      res_valid  <= res_valid_d;
      res_spins  <= res_spins_d;
      busy       <= busy_d;
      err        <= err_d;
    end
  end

  ising_phase_reader #(
    .N (N)
  ) u_rd (
    .clk    (clk),
    .rst    (rst),
    .start  (rd_start),
    .cutoff (cut_q),
    .rdata  (rdata),
    .araddr (araddr),
    .done   (rd_done),
    .spins  (rd_spins)
  );

endmodule

// File: tb/tb_ising_loader.sv
// tb_ising_loader: drives command/edge streams into ising_loader with a
// behavioural ising_axi stub and checks writes, timing and spins.
module tb_ising_loader;
  import ising_pkg::*;

  localparam int N     = 6;
  localparam int NW    = 5;
  localparam int RUN_W = 32;
  localparam int IW    = $clog2(N);
  localparam int WW    = $clog2(NW);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_start = 1'b0;
  logic [31:0]      ctr_cutoff = '0;
  logic [31:0]      ctr_max = '0;
  logic [31:0]      start_val = '0;
  logic [RUN_W-1:0] run_cycles = '0;
  logic             edge_valid = 1'b0;
  logic             edge_ready;
  logic [IW-1:0]    edge_i = '0;
  logic [IW-1:0]    edge_j = '0;
  logic [WW-1:0]    edge_w = '0;
  logic             edge_last = 1'b0;
  logic             wready;
  logic [31:0]      wr_addr;
  logic [31:0]      wdata;
  logic [31:0]      araddr;
  logic [31:0]      rdata = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [N-1:0]     res_spins;
  logic             busy;
  logic             err;

  ising_loader #(
    .N           (N),
    .NUM_WEIGHTS (NW),
    .RUN_W       (RUN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_start  (cmd_start),
    .ctr_cutoff (ctr_cutoff),
    .ctr_max    (ctr_max),
    .start_val  (start_val),
    .run_cycles (run_cycles),
    .edge_valid (edge_valid),
    .edge_ready (edge_ready),
    .edge_i     (edge_i),
    .edge_j     (edge_j),
    .edge_w     (edge_w),
    .edge_last  (edge_last),
    .wready     (wready),
    .wr_addr    (wr_addr),
    .wdata      (wdata),
    .araddr     (araddr),
    .rdata      (rdata),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_spins  (res_spins),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ising_axi stub: phase table by slot, one-cycle read latency
  logic [31:0] phase_tab [N];

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(PHASE_ADDR_BASE);
    if (off >= 0 && off < 4 * N && off % 4 == 0)
      return phase_tab[int'(off / 4)];
    return 32'hdead_beef;
  endfunction

  always @(posedge clk) rdata <= rd_model(araddr);

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wlog[$];
  logic [31:0] prev_ar = '0;
  int          first_rd = -1;

  always @(negedge clk) begin
    if (wready) wlog.push_back('{cyc, wr_addr, wdata});
    if (araddr !== prev_ar &&
        araddr == PHASE_ADDR_BASE + 32'((N - 1) * 4))
      first_rd = cyc;
    prev_ar = araddr;
  end

  int          qi[$];
  int          qj[$];
  int          qw[$];
  logic [31:0] nph [N];

  function automatic logic [31:0] wa(input int r, input int c);
    return WEIGHT_ADDR_BASE + 32'(r) * 4 + 32'(c) * 8192;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [31:0] cut,
                        input logic [31:0] mx,
                        input logic [31:0] sv,
                        input int          rc,
                        input int          hold,
                        input bit          poke);
    logic [31:0]  ea[$];
    logic [31:0]  ed[$];
    bit           gap2[$];
    int           hs[$];
    bit           exp_err;
    logic [N-1:0] exp_sp;
    logic [N-1:0] sp;
    int           c0;
    int           n;

    for (int k = 0; k < N; k++) phase_tab[N-1-k] = nph[k];

    exp_err = 1'b0;
    ea.push_back(CTR_CUTOFF_ADDR); ed.push_back(cut);
    ea.push_back(CTR_MAX_ADDR);    ed.push_back(mx);
    foreach (qi[e]) begin
      if (qi[e] >= N || qj[e] >= N) begin
        exp_err = 1'b1;
        gap2.push_back(1'b0);
      end else if (qi[e] == qj[e]) begin
        ea.push_back(wa(qi[e], qi[e])); ed.push_back(32'(qw[e]));
        gap2.push_back(1'b0);
      end else begin
        ea.push_back(wa(qi[e], qj[e])); ed.push_back(32'(qw[e]));
        ea.push_back(wa(qj[e], qi[e])); ed.push_back(32'(qw[e]));
        gap2.push_back(1'b1);
      end
    end
    ea.push_back(START_ADDR); ed.push_back(sv);
    for (int k = 0; k < N; k++) exp_sp[k] = (nph[k] >= cut);

    @(posedge clk); #1;
    wlog.delete();
    first_rd = -1;
    c0 = cyc;
    cmd_start  = 1'b1;
    ctr_cutoff = cut;
    ctr_max    = mx;
    start_val  = sv;
    run_cycles = RUN_W'(rc);
    @(posedge clk); #1;
    cmd_start  = 1'b0;
    ctr_cutoff = $urandom;
    ctr_max    = $urandom;
    start_val  = $urandom;
    run_cycles = RUN_W'($urandom_range(50, 90));
    @(negedge clk);
    chk("busy_after_cmd", 64'(busy), 64'(1));
    chk("err_cleared", 64'(err), 64'(0));
    chk("edge_ready_early", 64'(edge_ready), 64'(0));
    @(posedge clk); #1;

    foreach (qi[e]) begin
      edge_valid = 1'b1;
      edge_i     = IW'(qi[e]);
      edge_j     = IW'(qj[e]);
      edge_w     = WW'(qw[e]);
      edge_last  = (e == qi.size() - 1);
      n = 0;
      forever begin
        @(negedge clk);
        if (edge_ready || n > 50) break;
        n++;
        @(posedge clk); #1;
      end
      if (!edge_ready) begin
        chk("edge_ready_wait", 64'(edge_ready), 64'(1));
        edge_valid = 1'b0;
        break;
      end
      hs.push_back(cyc);
      @(posedge clk); #1;
    end
    edge_valid = 1'b0;
    edge_last  = 1'b0;

    if (hs.size() > 0) chk("edge_ready_lat", 64'(hs[0]), 64'(c0 + 3));
    for (int e = 1; e < hs.size(); e++)
      chk("edge_gap", 64'(hs[e] - hs[e-1]), 64'(gap2[e-1] ? 2 : 1));

    res_ready = (hold == 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 3000);
    chk("res_valid_seen", 64'(res_valid), 64'(1));

    sp = res_spins;
    for (int h = 0; h < hold; h++) begin
      chk("bp_valid", 64'(res_valid), 64'(1));
      chk("bp_spins", 64'(res_spins), 64'(sp));
      @(posedge clk); #1;
      cmd_start = poke && (h == 3);
      @(negedge clk);
    end
    cmd_start = 1'b0;
    res_ready = 1'b1;

    chk("res_spins", 64'(res_spins), 64'(exp_sp));
    chk("err", 64'(err), 64'(exp_err));
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("res_valid_drop", 64'(res_valid), 64'(0));
    chk("busy_drop", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);

    chk("wlog_size", 64'(wlog.size()), 64'(ea.size()));
    for (int w = 0; w < wlog.size() && w < ea.size(); w++) begin
      chk("wr_addr", 64'(wlog[w].a), 64'(ea[w]));
      chk("wr_data", 64'(wlog[w].d), 64'(ed[w]));
    end
    if (wlog.size() >= 2) begin
      chk("cut_cycle", 64'(wlog[0].c), 64'(c0 + 1));
      chk("max_cycle", 64'(wlog[1].c), 64'(c0 + 2));
    end
    if (wlog.size() > 0)
      chk("run_timing", 64'(first_rd - wlog[$].c), 64'(rc + 1));
  endtask

  initial begin
    int n;
    int ne;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wready", 64'(wready), 64'(0));
    chk("rst_edge_ready", 64'(edge_ready), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    chk("rst_araddr", 64'(araddr), 64'(0));
    chk("rst_res_spins", 64'(res_spins), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // max-cut: five nodes plus hub node 5
    qi = '{0, 1, 0, 2, 3, 0, 1, 2, 3, 4};
    qj = '{1, 2, 4, 3, 4, 5, 5, 5, 5, 5};
    qw = '{1, 2, 3, 4, 1, 2, 3, 4, 0, 1};
    nph = '{32'd6, 32'd2, 32'd7, 32'd5, 32'd1, 32'd6};
    do_cmd(32'd4, 32'd8, 32'd1, 3, 0, 1'b0);
    chk("maxcut_spins", 64'(res_spins), 64'(6'b101101));

    // diagonal edges interleaved with an off-diagonal one
    qi = '{1, 2, 4};
    qj = '{1, 3, 4};
    qw = '{0, 2, 4};
    nph = '{32'd0, 32'd9, 32'd3, 32'd3, 32'hffff_ffff, 32'd2};
    do_cmd(32'd3, 32'd7, 32'h1234_5678, 0, 0, 1'b0);

    // out-of-range indices, later edges still written
    qi = '{7, 0, 3, 1};
    qj = '{2, 3, 3, 6};
    qw = '{1, 2, 3, 4};
    nph = '{32'd8, 32'd1, 32'd5, 32'd4, 32'd0, 32'd7};
    do_cmd(32'd5, 32'd9, 32'hcafe_0001, 5, 0, 1'b0);

    // back-pressure with a dropped cmd_start
    qi = '{2, 5};
    qj = '{4, 0};
    qw = '{3, 1};
    nph = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    do_cmd(32'd4, 32'd6, 32'd2, 1, 10, 1'b1);

    // reset in the middle of the edge phase
    qi = '{0, 1, 2};
    qj = '{1, 2, 3};
    @(posedge clk); #1;
    wlog.delete();
    cmd_start  = 1'b1;
    run_cycles = RUN_W'(2);
    @(posedge clk); #1;
    cmd_start = 1'b0;
    for (int e = 0; e < 3; e++) begin
      edge_valid = 1'b1;
      edge_i     = IW'(qi[e]);
      edge_j     = IW'(qj[e]);
      edge_w     = WW'(e);
      edge_last  = 1'b0;
      n = 0;
      forever begin
        @(negedge clk);
        if (edge_ready || n > 50) break;
        n++;
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    chk("wready_before_rst", 64'(wready), 64'(1));
    rst = 1'b1;
    edge_valid = 1'b0;
    #1;
    chk("rst_mid_wready", 64'(wready), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_edge_ready", 64'(edge_ready), 64'(0));
    n = wlog.size();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_no_write", 64'(wlog.size()), 64'(n));
    chk("rst_idle", 64'(busy), 64'(0));

    qi = '{0, 3};
    qj = '{5, 1};
    qw = '{4, 2};
    nph = '{32'd9, 32'd0, 32'd4, 32'd3, 32'd4, 32'd5};
    do_cmd(32'd4, 32'd8, 32'd3, 2, 0, 1'b0);

    // randomized commands
    for (int t = 0; t < 6; t++) begin
      qi.delete();
      qj.delete();
      qw.delete();
      ne = $urandom_range(1, 7);
      for (int e = 0; e < ne; e++) begin
        qi.push_back($urandom_range(0, 6));
        qj.push_back(($urandom_range(0, 3) == 0) ?
                     qi[e] : $urandom_range(0, 6));
        qw.push_back($urandom_range(0, 4));
      end
      for (int k = 0; k < N; k++) nph[k] = 32'($urandom_range(0, 9));
      do_cmd(32'($urandom_range(1, 9)), $urandom, $urandom,
             $urandom_range(0, 7), (t % 3 == 2) ? 4 : 0, t[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ising_loader.md
# ising_loader

Sequencing master that sits directly upstream of `ising_axi` and drives its write and read ports in place of a software host. It takes one command plus a stream of coupling edges and runs the full sequence:

- programs the counter cutoff and maximum;
- writes each coupling symmetrically (both triangle entries);
- writes the start word, then waits a programmable run time;
- reads all N phase registers and returns the thresholded spin vector over a valid/ready handshake.

## Interface
- `N`, 8: spin count; must match `ising_axi.N`.
- `NUM_WEIGHTS`, 5: weight levels; weight code width `WW = $clog2(NUM_WEIGHTS)`.
- `RUN_W`, 32: width of the run-time counter.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_start` in 1: one-cycle command pulse; ignored while `busy`.
- `ctr_cutoff` in 32: sampled at `cmd_start`; written to `CTR_CUTOFF_ADDR` and used as the phase threshold.
- `ctr_max` in 32: sampled at `cmd_start`; written to `CTR_MAX_ADDR`.
- `start_val` in 32: sampled at `cmd_start`; written to `START_ADDR`.
- `run_cycles` in RUN_W: sampled at `cmd_start`; number of idle cycles after the start write.
- `edge_valid` in 1, `edge_ready` out 1: edge handshake.
- `edge_i`, `edge_j` in $clog2(N): spin indices.
- `edge_w` in WW: raw weight code.
- `edge_last` in 1: marks the final edge of the command.
- `wready` out 1: write strobe to `ising_axi`; every cycle it is high is one write.
- `wr_addr` out 32, `wdata` out 32: write address and data.
- `araddr` out 32: read address to `ising_axi` (its `arvalid_q` is tied 1).
- `rdata` in 32: read data, valid one cycle after `araddr`.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_spins` out N: bit k = spin k.
- `busy` out 1: high from the cycle after an accepted `cmd_start` until the result handshake completes.
- `err` out 1: sticky until the next accepted `cmd_start`; set when an edge index is ≥ N.

## Operation
- **FSM states:** IDLE → CFG_CUT → CFG_MAX → EDGE → (EDGE_B) → START → RUN → READ → RESULT → IDLE.
- **IDLE:** all outputs deasserted. `cmd_start` latches the four config inputs and clears `err`.
- **CFG_CUT / CFG_MAX:** one write each: (`CTR_CUTOFF_ADDR`, cutoff), then (`CTR_MAX_ADDR`, max).
- **EDGE:** `edge_ready` = 1. Address function A(r,c) = `WEIGHT_ADDR_BASE + (r<<2) + (c<<13)`. On handshake:
  - i≠j: write A(i,j) with `wdata = {zero, edge_w}`, then go to EDGE_B, which writes A(j,i) with `edge_ready` = 0.
  - i==j: single write A(i,i). This is the initial-spin programming path.
  - i or j ≥ N: set `err`, issue no write, and consume the edge.
  - After the last write of an edge with `edge_last` set, go to START.
- **START:** one write (`START_ADDR`, start_val). Load the down-counter with `run_cycles`.
- **RUN:** decrement each cycle. Exit when the counter is 0, so `run_cycles` = 0 passes straight through in one cycle.
- **READ:** pipelined, one address per cycle.
  - Cycle t presents `PHASE_ADDR_BASE + ((N-1-k)<<2)` for k = t; spin k lives in phase slot N-1-k.
  - `rdata` captured in cycle t+1 gives `spin[k] = (rdata >= cutoff)`, unsigned 32-bit compare.
  - Total N+1 cycles.
- **RESULT:** `res_valid` = 1 and `res_spins` held stable until `res_ready`; the handshake cycle returns to IDLE.
- `araddr` holds its last value outside READ; `wr_addr`/`wdata` are don't-care while `wready` = 0.

## Timing
- All outputs are registered.
- **Reset values:** `wready`, `edge_ready`, `res_valid`, `busy`, `err` = 0; `wr_addr`, `wdata`, `araddr`, `res_spins` = 0; FSM in IDLE.
- **Command latency:** `cmd_start` at cycle 0 → cutoff write at cycle 1 → max write at cycle 2 → `edge_ready` first high at cycle 3.
- **Edge throughput:** off-diagonal edges take 2 cycles each; diagonal and error edges take 1.
- `rst` asserted mid-sequence returns to IDLE immediately with `wready` = 0. No partial write completes after reset.
- `cmd_start` while `busy` is dropped; no queueing.
- A `res_ready` already high when `res_valid` rises completes the handshake in that same cycle.

## Structure
- **Shared package `ising_pkg`:** address constants `WEIGHT_ADDR_BASE`, `START_ADDR`, `CTR_CUTOFF_ADDR`, `CTR_MAX_ADDR`, `PHASE_ADDR_BASE`, row shift 2, column shift 13, and the FSM state enum. `ising_axi` reads the same constants.
- **Sub-module `ising_phase_reader`:** READ-phase address generator, capture pipeline and comparator, with a start pulse in and a done pulse plus spin vector out.
- Everything else lives in one FSM module.

## Test plan
- **Max-cut:** `ising_axi` behavioural stub (register file plus programmable phase table), 5-node graph with couplings to H, cutoff 4, max 8.
  - Write log shows AB, BA, AE, EA … EH, HE, in that order.
  - Phases {A..H} = {6,2,7,5,1,x,x,6} → `res_spins` bits A, C, D, H = 1 and B, E = 0.
- **Diagonal edge:** i=j=1, w=0 → exactly one write to A(1,1); `edge_ready` high on the very next cycle.
- **Out-of-range edge:** N=6, edge i=7 → `err` = 1, no write, following edges still programmed; `err` clears on the next `cmd_start`.
- **Run timing:** `run_cycles` = 0 → first `araddr` the cycle after the START write; `run_cycles` = 5 → it follows 5 cycles later.
- **Back-pressure:** `res_ready` held low for 10 cycles → `res_valid` and `res_spins` stable throughout; a `cmd_start` during this window is ignored.
- **Reset mid-EDGE:** `rst` pulsed after 3 edges → `wready` = 0 in the reset cycle; a fresh command then completes normally.
